// File: rtl/rs_mul_sched_pkg.sv
// Shared constants and state encodings for the multiply reservation-station scheduler.
// The RS_MUL_SCHED_B2B_EN build option is consumed in rs_mul_sched.sv.
package rs_mul_sched_pkg;

  localparam int RS_MUL_ENT_NUM = 2;
  localparam int RS_MUL_ENT_SEL = 1;
  localparam int RRF_ENT_SEL    = 6;
  localparam int MUL_LAT_CYC    = 3;

  typedef enum logic [1:0] {
    RS_MUL_SCHED_IDLE    = 2'd0,
    RS_MUL_SCHED_BUSY    = 2'd1,
    RS_MUL_SCHED_WAIT_WB = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rs_mul_sched_rr_pick2.sv
// Round-robin picker for a 2-entry request vector: prefers the entry at ptr,
// otherwise falls back to the other one.
module rr_pick2 #(
  parameter int ENT_NUM = 2,
  parameter int ENT_SEL = 1
) (
  input  logic [ENT_NUM-1:0] req_vec,
  input  logic [ENT_SEL-1:0] ptr,
  output logic               vld,
  output logic [ENT_SEL-1:0] sel
);

  assign vld = |req_vec;
  assign sel = req_vec[ptr] ? ptr : ~ptr;

endmodule

// File: rtl/rs_mul_sched.sv
// Multiply RS scheduler: dispatch allocation, round-robin issue and multiplier sequencing.
// Define RS_MUL_SCHED_B2B_EN to allow a new issue in the same cycle as the CDB grant.
module rs_mul_sched
  import rs_mul_sched_pkg::*;
#(
  parameter int ENT_NUM = RS_MUL_ENT_NUM,
  parameter int ENT_SEL = RS_MUL_ENT_SEL,
  parameter int RRF_SEL = RRF_ENT_SEL,
  parameter int MUL_LAT = MUL_LAT_CYC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ENT_NUM-1:0] i_busy_vec,
  input  logic [ENT_NUM-1:0] i_vld_vec,
  input  logic               i_kill,
  input  logic               i_dp_req_1,
  input  logic               i_dp_req_2,
  output logic               o_alloc_vld_1,
  output logic [ENT_SEL-1:0] o_alloc_sel_1,
  output logic               o_alloc_vld_2,
  output logic [ENT_SEL-1:0] o_alloc_sel_2,
  output logic               o_dp_stall,
  output logic               o_is_vld,
  output logic [ENT_SEL-1:0] o_is_sel,
  input  logic [RRF_SEL-1:0] i_is_rrftag,
  output logic               o_mul_start,
  output logic               o_wb_req,
  output logic [RRF_SEL-1:0] o_ex_mul_rrftag,
  input  logic               i_wb_gnt
);

  localparam int CNT_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT);
  localparam int FC_W  = ENT_SEL + 1;

  sched_state_e       state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [RRF_SEL-1:0] tag_reg, tag_next;
  logic [ENT_SEL-1:0] ptr_reg, ptr_next;

  logic [ENT_NUM-1:0] free, rdy;
  logic [FC_W-1:0]    free_cnt, req_cnt;
  logic               first_vld, second_vld, stall;
  logic [ENT_SEL-1:0] first_sel, second_sel;
  logic               pick_vld, issue_ok, do_issue, wb_req;
  logic [ENT_SEL-1:0] pick_sel;

  // Allocation: lowest free entry, then lowest free entry other than that one.
  always_comb begin
    free       = ~i_busy_vec;
    free_cnt   = '0;
    first_vld  = 1'b0;
    first_sel  = '0;
    second_vld = 1'b0;
    second_sel = '0;
    for (int i = 0; i < ENT_NUM; i++) begin
      if (free[i]) begin
        free_cnt = free_cnt + FC_W'(1);
        if (!first_vld) begin
          first_vld = 1'b1;
          first_sel = ENT_SEL'(i);
        end else if (!second_vld) begin
          second_vld = 1'b1;
          second_sel = ENT_SEL'(i);
        end
      end
    end
    req_cnt       = FC_W'(i_dp_req_1) + FC_W'(i_dp_req_2);
    stall         = free_cnt < req_cnt;
    o_dp_stall    = stall;
    o_alloc_vld_1 = i_dp_req_1 & ~stall & ~i_kill;
    o_alloc_vld_2 = i_dp_req_2 & ~stall & ~i_kill;
    o_alloc_sel_1 = first_sel;
    o_alloc_sel_2 = i_dp_req_1 ? second_sel : first_sel;
  end

  assign rdy = i_busy_vec & i_vld_vec;

  rr_pick2 #(
    .ENT_NUM (ENT_NUM),
    .ENT_SEL (ENT_SEL)
  ) u_pick (
    .req_vec (rdy),
    .ptr     (ptr_reg),
    .vld     (pick_vld),
    .sel     (pick_sel)
  );

  // Reset gating keeps the comb issue pulse quiet while the block is held in reset.
  assign issue_ok = pick_vld & ~i_kill & ~rst;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    tag_next   = tag_reg;
    ptr_next   = ptr_reg;
    do_issue   = 1'b0;
    wb_req     = 1'b0;
    case (state_reg)
      RS_MUL_SCHED_IDLE: do_issue = issue_ok;
      RS_MUL_SCHED_BUSY: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) state_next = RS_MUL_SCHED_WAIT_WB;
      end
      RS_MUL_SCHED_WAIT_WB: begin
        wb_req = 1'b1;
        if (i_wb_gnt) begin
          state_next = RS_MUL_SCHED_IDLE;
`ifdef RS_MUL_SCHED_B2B_EN
          do_issue = issue_ok;
`endif
        end
      end
      default: state_next = RS_MUL_SCHED_IDLE;
    endcase
    if (do_issue) begin
      tag_next   = i_is_rrftag;
      cnt_next   = CNT_W'(MUL_LAT - 1);
      ptr_next   = (pick_sel == ENT_SEL'(ENT_NUM - 1)) ? '0 : pick_sel + ENT_SEL'(1);
      state_next = (MUL_LAT == 1) ? RS_MUL_SCHED_WAIT_WB : RS_MUL_SCHED_BUSY;
    end
    // Flush wins over everything, including a coincident grant.
    if (i_kill) begin
      state_next = RS_MUL_SCHED_IDLE;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RS_MUL_SCHED_IDLE;
      cnt_reg   <= '0;
      tag_reg   <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      tag_reg   <= tag_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign o_is_vld        = do_issue;
  assign o_mul_start     = do_issue;
  assign o_is_sel        = do_issue ? pick_sel : '0;
  assign o_wb_req        = wb_req;
  assign o_ex_mul_rrftag = tag_reg;

endmodule

// File: tb/tb_rs_mul_sched.sv
// Directed bench for rs_mul_sched with hand-computed expectations (MUL_LAT=3).
// Expectations for the grant-cycle issue follow RS_MUL_SCHED_B2B_EN when defined.
module tb_rs_mul_sched;

`ifdef RS_MUL_SCHED_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] i_busy_vec, i_vld_vec;
  logic       i_kill, i_dp_req_1, i_dp_req_2;
  logic       o_alloc_vld_1, o_alloc_vld_2, o_dp_stall;
  logic [0:0] o_alloc_sel_1, o_alloc_sel_2, o_is_sel;
  logic       o_is_vld, o_mul_start, o_wb_req, i_wb_gnt;
  logic [5:0] i_is_rrftag, o_ex_mul_rrftag;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rs_mul_sched dut (
    .clk             (clk),
    .rst             (rst),
    .i_busy_vec      (i_busy_vec),
    .i_vld_vec       (i_vld_vec),
    .i_kill          (i_kill),
    .i_dp_req_1      (i_dp_req_1),
    .i_dp_req_2      (i_dp_req_2),
    .o_alloc_vld_1   (o_alloc_vld_1),
    .o_alloc_sel_1   (o_alloc_sel_1),
    .o_alloc_vld_2   (o_alloc_vld_2),
    .o_alloc_sel_2   (o_alloc_sel_2),
    .o_dp_stall      (o_dp_stall),
    .o_is_vld        (o_is_vld),
    .o_is_sel        (o_is_sel),
    .i_is_rrftag     (i_is_rrftag),
    .o_mul_start     (o_mul_start),
    .o_wb_req        (o_wb_req),
    .o_ex_mul_rrftag (o_ex_mul_rrftag),
    .i_wb_gnt        (i_wb_gnt)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end else begin
      $display("  ok %s = %0h", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow #1 later.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; i_busy_vec = 2'b00; i_vld_vec = 2'b00; i_kill = 1'b0;
    i_dp_req_1 = 1'b0; i_dp_req_2 = 1'b0; i_is_rrftag = 6'h00; i_wb_gnt = 1'b0;
    cyc(); #1;
    chk("rst_is_vld", 32'(o_is_vld), 0);
    chk("rst_wb_req", 32'(o_wb_req), 0);
    chk("rst_tag", 32'(o_ex_mul_rrftag), 0);
    chk("rst_stall", 32'(o_dp_stall), 0);
    chk("rst_alloc_vld_1", 32'(o_alloc_vld_1), 0);
    cyc(); rst = 1'b0;

    // Allocation vectors
    i_busy_vec = 2'b01; i_dp_req_1 = 1'b1; i_dp_req_2 = 1'b1; #1;
    chk("a1_stall", 32'(o_dp_stall), 1);
    chk("a1_vld_1", 32'(o_alloc_vld_1), 0);
    chk("a1_vld_2", 32'(o_alloc_vld_2), 0);
    i_dp_req_1 = 1'b0; #1;
    chk("a2_vld_2", 32'(o_alloc_vld_2), 1);
    chk("a2_sel_2", 32'(o_alloc_sel_2), 1);
    chk("a2_stall", 32'(o_dp_stall), 0);
    i_busy_vec = 2'b00; i_dp_req_1 = 1'b1; #1;
    chk("a3_sel_1", 32'(o_alloc_sel_1), 0);
    chk("a3_sel_2", 32'(o_alloc_sel_2), 1);
    chk("a3_vld_1", 32'(o_alloc_vld_1), 1);
    chk("a3_vld_2", 32'(o_alloc_vld_2), 1);
    i_busy_vec = 2'b10; i_dp_req_2 = 1'b0; #1;
    chk("a4_sel_1", 32'(o_alloc_sel_1), 0);
    chk("a4_vld_1", 32'(o_alloc_vld_1), 1);
    i_kill = 1'b1; #1;
    chk("a5_kill_vld_1", 32'(o_alloc_vld_1), 0);
    chk("a5_kill_stall", 32'(o_dp_stall), 0);
    i_kill = 1'b0; i_busy_vec = 2'b11; #1;
    chk("a6_full_stall", 32'(o_dp_stall), 1);
    i_dp_req_1 = 1'b0;

    // Round-robin issue with grant held high
    cyc(); i_busy_vec = 2'b11; i_vld_vec = 2'b11; i_is_rrftag = 6'h11; i_wb_gnt = 1'b1; #1;
    chk("rr_t0_is_vld", 32'(o_is_vld), 1);
    chk("rr_t0_is_sel", 32'(o_is_sel), 0);
    chk("rr_t0_start", 32'(o_mul_start), 1);
    cyc(); #1;
    chk("rr_t1_is_vld", 32'(o_is_vld), 0);
    chk("rr_t1_tag", 32'(o_ex_mul_rrftag), 'h11);
    cyc(); #1;
    chk("rr_t2_wb_req", 32'(o_wb_req), 0);
    cyc(); i_is_rrftag = 6'h12; #1;
    chk("rr_t3_wb_req", 32'(o_wb_req), 1);
    chk("rr_t3_tag", 32'(o_ex_mul_rrftag), 'h11);
    chk("rr_t3_is_vld", 32'(o_is_vld), 32'(B2B));
    chk("rr_t3_is_sel", 32'(o_is_sel), 32'(B2B));
    cyc(); #1;
    chk("rr_t4_is_vld", 32'(o_is_vld), 32'(!B2B));
    chk("rr_t4_is_sel", 32'(o_is_sel), 32'(!B2B));
    chk("rr_t4_wb_req", 32'(o_wb_req), 0);
    cyc(); i_vld_vec = 2'b00; i_kill = 1'b1; #1;
    chk("flush_is_vld", 32'(o_is_vld), 0);
    cyc(); i_kill = 1'b0; i_wb_gnt = 1'b0;

    // Withheld grant: tag and request hold steady
    i_vld_vec = 2'b01; i_is_rrftag = 6'h2A; #1;
    chk("hold_t0_is_sel", 32'(o_is_sel), 0);
    chk("hold_t0_is_vld", 32'(o_is_vld), 1);
    cyc(); i_vld_vec = 2'b00; i_is_rrftag = 6'h3F;
    cyc();
    for (int k = 0; k < 5; k++) begin
      cyc(); #1;
      chk($sformatf("hold_w%0d_wb_req", k), 32'(o_wb_req), 1);
      chk($sformatf("hold_w%0d_tag", k), 32'(o_ex_mul_rrftag), 'h2A);
    end
    cyc(); i_wb_gnt = 1'b1; #1;
    chk("hold_gnt_wb_req", 32'(o_wb_req), 1);
    cyc(); i_wb_gnt = 1'b0; #1;
    chk("hold_after_wb_req", 32'(o_wb_req), 0);

    // Kill in BUSY with cnt==1
    cyc(); i_vld_vec = 2'b11; i_is_rrftag = 6'h05; #1;
    chk("kill_t0_is_sel", 32'(o_is_sel), 1);
    cyc();
    cyc(); i_kill = 1'b1; #1;
    chk("kill_t2_is_vld", 32'(o_is_vld), 0);
    cyc(); i_kill = 1'b0; i_is_rrftag = 6'h07; #1;
    chk("kill_t3_is_vld", 32'(o_is_vld), 1);
    chk("kill_t3_is_sel", 32'(o_is_sel), 0);
    chk("kill_t3_wb_req", 32'(o_wb_req), 0);
    cyc(); i_vld_vec = 2'b00; #1;
    chk("kill_t4_wb_req", 32'(o_wb_req), 0);
    cyc(); #1;
    chk("kill_t5_wb_req", 32'(o_wb_req), 0);
    cyc(); i_wb_gnt = 1'b1; #1;
    chk("kill_t6_wb_req", 32'(o_wb_req), 1);
    chk("kill_t6_tag", 32'(o_ex_mul_rrftag), 'h07);
    cyc(); i_wb_gnt = 1'b0; #1;
    chk("kill_t7_wb_req", 32'(o_wb_req), 0);

    // Asynchronous reset in WAIT_WB
    cyc(); i_vld_vec = 2'b01; i_is_rrftag = 6'h3C; #1;
    chk("ar_t0_is_sel", 32'(o_is_sel), 0);
    cyc(); i_vld_vec = 2'b00;
    cyc();
    cyc(); #1;
    chk("ar_t3_wb_req", 32'(o_wb_req), 1);
    i_vld_vec = 2'b11; rst = 1'b1; #1;
    chk("ar_rst_wb_req", 32'(o_wb_req), 0);
    chk("ar_rst_is_vld", 32'(o_is_vld), 0);
    chk("ar_rst_tag", 32'(o_ex_mul_rrftag), 0);
    cyc(); rst = 1'b0; #1;
    chk("ar_post_is_vld", 32'(o_is_vld), 1);
    chk("ar_post_is_sel", 32'(o_is_sel), 0);
    chk("ar_post_wb_req", 32'(o_wb_req), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
